// File: rtl/sha_tag_append_pkg.sv
// rtl/sha_tag_append_pkg.sv - shared types and constants for the tag-append block
//
// Purpose : FSM state encoding, tag beat size and default stream-ID width,
//           shared by the stream interface and the tag-append top.
// Ports   : none (package).
package sha_tag_append_pkg;

    localparam int TID_BITS       = 6;
    localparam int TAG_BYTES      = 64;
    localparam int AXIS_DATA_BITS = TAG_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DATA     = 2'd1,
        ST_WAIT_TAG = 2'd2,
        ST_TAG      = 2'd3
    } state_e;

endpackage

// File: rtl/sha_tag_append_if.sv
// rtl/sha_tag_append_if.sv - stream bundle (tvalid/tready/tdata/tkeep/tid/tlast)
//
// Purpose : one packet stream with a ready/valid handshake.
// Ports   : master drives tvalid/tdata/tkeep/tid/tlast and samples tready;
//           slave is the mirror image.
interface sha_tag_append_if #(
    parameter int DATA_W = sha_tag_append_pkg::AXIS_DATA_BITS,
    parameter int TID_W  = sha_tag_append_pkg::TID_BITS
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [TID_W-1:0]  tid;
    logic              tlast;

    modport master (output tvalid, tdata, tkeep, tid, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tid, tlast, output tready);

endinterface

// File: rtl/sha_tag_append.sv
// rtl/sha_tag_append.sv - fork packet to signing engine, append returned tag beat
//
// Purpose : Sits on the transmit path between the input and output FIFOs.
//           Each packet is forked losslessly to the host output and to the
//           signing engine; after the last beat the block waits for one
//           digest beat and emits it as a trailing tag beat on the host output.
// Ports   : aclk          - clock, rising edge
//           areset        - synchronous active-low reset
//           s_axis_host   - plaintext packet in (slave)
//           m_axis_host   - packet out with appended tag beat (master)
//           hash_axis     - packet copy to the signing engine (master)
//           digest_tvalid/digest_tready/digest_tdata - tag from the engine
//           tag_count     - tag beats emitted since reset (wrapping)
module sha_tag_append #(
    parameter int AXIS_TDATA_WIDTH = sha_tag_append_pkg::AXIS_DATA_BITS,
    parameter int TID_BITS         = sha_tag_append_pkg::TID_BITS
) (
    input  logic                        aclk,
    input  logic                        areset,
    sha_tag_append_if.slave             s_axis_host,
    sha_tag_append_if.master            m_axis_host,
    sha_tag_append_if.master            hash_axis,
    input  logic                        digest_tvalid,
    output logic                        digest_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] digest_tdata,
    output logic [31:0]                 tag_count
);
    import sha_tag_append_pkg::*;

    localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [AXIS_TDATA_WIDTH-1:0] r_digest;
    logic [TID_BITS-1:0]         r_tid;
    logic [31:0]                 r_tag_count;

    logic w_pass;
    logic w_tag;
    logic w_in_xfer;
    logic w_tag_xfer;
    logic w_digest_xfer;

    // Data phase: the fork is only open while reset is released, and a beat
    // moves only when both destinations can take it in the same cycle.
    assign w_pass        = areset && ((r_state == ST_IDLE) || (r_state == ST_DATA));
    assign w_tag         = areset && (r_state == ST_TAG);
    assign w_in_xfer     = w_pass && s_axis_host.tvalid && m_axis_host.tready && hash_axis.tready;
    assign w_tag_xfer    = w_tag && m_axis_host.tready;
    assign w_digest_xfer = digest_tvalid && digest_tready;

    // Each output's valid excludes its own ready so neither side can see a
    // beat the other side is not also taking.
    assign s_axis_host.tready = w_pass && m_axis_host.tready && hash_axis.tready;

    assign m_axis_host.tvalid = (w_pass && s_axis_host.tvalid && hash_axis.tready) || w_tag;
    assign m_axis_host.tdata  = w_tag ? r_digest : s_axis_host.tdata;
    assign m_axis_host.tkeep  = w_tag ? {KEEP_W{1'b1}} : s_axis_host.tkeep;
    assign m_axis_host.tid    = w_tag ? r_tid : s_axis_host.tid;
    assign m_axis_host.tlast  = w_tag;

    assign hash_axis.tvalid = w_pass && s_axis_host.tvalid && m_axis_host.tready;
    assign hash_axis.tdata  = s_axis_host.tdata;
    assign hash_axis.tkeep  = s_axis_host.tkeep;
    assign hash_axis.tid    = s_axis_host.tid;
    assign hash_axis.tlast  = s_axis_host.tlast;

    // A digest offered early simply waits here until the packet has ended.
    assign digest_tready = areset && (r_state == ST_WAIT_TAG);
    assign tag_count     = r_tag_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DATA: begin
                if (w_in_xfer) begin
                    w_state_next = s_axis_host.tlast ? ST_WAIT_TAG : ST_DATA;
                end
            end
            ST_WAIT_TAG: begin
                if (w_digest_xfer) begin
                    w_state_next = ST_TAG;
                end
            end
            ST_TAG: begin
                if (w_tag_xfer) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset) begin
            r_state     <= ST_IDLE;
            r_digest    <= '0;
            r_tid       <= '0;
            r_tag_count <= '0;
        end else begin
            r_state <= w_state_next;
            // The tag carries the ID of the packet's first beat.
            if ((r_state == ST_IDLE) && w_in_xfer) begin
                r_tid <= s_axis_host.tid;
            end
            if (w_digest_xfer) begin
                r_digest <= digest_tdata;
            end
            if (w_tag_xfer) begin
                r_tag_count <= r_tag_count + 32'd1;
            end
        end
    end

endmodule
